// File: rtl/clk_div_prog.sv
// Programmable clock divider. Produces a divided clock and a period-start tick.
// New divisor/high-time values wait in shadow registers and take effect only at a period boundary.
module clk_div_prog #(
  parameter int WIDTH      = 16,
  parameter int DIV_RESET  = 4,
  parameter int HIGH_RESET = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] div,
  input  logic [WIDTH-1:0] high,
  input  logic             load,
  output logic             pending,
  output logic             err,
  output logic             clk_out,
  output logic             tick,
  output logic [WIDTH-1:0] cnt
);

  localparam logic [WIDTH-1:0] DivRst  = WIDTH'(DIV_RESET);
  localparam logic [WIDTH-1:0] HighRst = WIDTH'(HIGH_RESET);
  localparam logic [WIDTH-1:0] One     = WIDTH'(1);
  localparam logic [WIDTH-1:0] Two     = WIDTH'(2);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_a_q, div_a_d, high_a_q, high_a_d;
  logic [WIDTH-1:0] div_s_q, div_s_d, high_s_q, high_s_d;
  logic             run_q, run_d;
  logic             pend_q, pend_d;
  logic             err_q, err_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             load_ok;
  logic             boundary;

  // div_a_q >= 2 always, so div_a_q - 1 never underflows and cnt_q + 1 never overflows.
  always_comb begin
    cnt_d    = cnt_q;
    run_d    = run_q;
    div_a_d  = div_a_q;
    high_a_d = high_a_q;
    div_s_d  = div_s_q;
    high_s_d = high_s_q;
    pend_d   = pend_q;
    err_d    = 1'b0;
    boundary = 1'b0;
    load_ok  = (div >= Two) && (high != '0) && (high < div);

    if (!en) begin
      cnt_d    = '0;
      run_d    = 1'b0;
      boundary = 1'b1;
    end else if (!run_q) begin
      cnt_d    = '0;
      run_d    = 1'b1;
      boundary = 1'b1;
    end else if (cnt_q == div_a_q - One) begin
      cnt_d    = '0;
      boundary = 1'b1;
    end else begin
      cnt_d = cnt_q + One;
    end

    if (boundary && pend_q) begin
      div_a_d  = div_s_q;
      high_a_d = high_s_q;
      pend_d   = 1'b0;
    end

    // A load on the boundary edge lands in the shadow after the old shadow was consumed.
    if (load) begin
      if (load_ok) begin
        div_s_d  = div;
        high_s_d = high;
        pend_d   = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end

    clk_out_d = run_d && (cnt_d < high_a_d);
    tick_d    = run_d && (cnt_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      run_q     <= 1'b0;
      div_a_q   <= DivRst;
      high_a_q  <= HighRst;
      div_s_q   <= DivRst;
      high_s_q  <= HighRst;
      pend_q    <= 1'b0;
      err_q     <= 1'b0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      run_q     <= run_d;
      div_a_q   <= div_a_d;
      high_a_q  <= high_a_d;
      div_s_q   <= div_s_d;
      high_s_q  <= high_s_d;
      pend_q    <= pend_d;
      err_q     <= err_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign cnt     = cnt_q;
  assign pending = pend_q;
  assign err     = err_q;
  assign clk_out = clk_out_q;
  assign tick    = tick_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: directed vector table, hand-written corner sequences,
// and a randomized run checked against a behavioural reference model.
module tb_clk_div_prog;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic [15:0] div = '0;
  logic [15:0] high = '0;
  logic        load = 1'b0;
  logic        pending, err, clk_out, tick;
  logic [15:0] cnt;

  int n_cmp = 0;
  int n_bad = 0;

  clk_div_prog #(.WIDTH(16), .DIV_RESET(4), .HIGH_RESET(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .div(div), .high(high), .load(load),
    .pending(pending), .err(err), .clk_out(clk_out), .tick(tick), .cnt(cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int en, ld, dv, hi;
    int e_cnt, e_clk, e_tick, e_pend, e_err;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(int e, int l, int d, int h, int c, int ck, int tk, int p, int er);
    vec_t r;
    r.en = e; r.ld = l; r.dv = d; r.hi = h;
    r.e_cnt = c; r.e_clk = ck; r.e_tick = tk; r.e_pend = p; r.e_err = er;
    return r;
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Drive inputs, let one rising edge pass, return 1 time unit after it.
  task automatic apply(int e, int l, int d, int h);
    en   = (e != 0);
    load = (l != 0);
    div  = 16'(d);
    high = 16'(h);
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  // One full period from its first cycle, checked for position, waveform and tick.
  task automatic run_period(int d, int h);
    int bad = 0;
    for (int i = 0; i < d; i++) begin
      apply(1, 0, 0, 0);
      if (int'(cnt) != i || int'(clk_out) != int'(i < h) || int'(tick) != int'(i == 0))
        bad++;
    end
    chk($sformatf("period %0d/%0d bad cycles", d, h), bad, 0);
  endtask

  // Reference model state
  int m_run, m_cnt, m_da, m_ha, m_ds, m_hs, m_pend, m_err, m_clk, m_tick;

  task automatic model_reset();
    m_run = 0; m_cnt = 0; m_da = 4; m_ha = 2; m_ds = 4; m_hs = 2;
    m_pend = 0; m_err = 0; m_clk = 0; m_tick = 0;
  endtask

  task automatic model_step(int e, int l, int d, int h);
    int pos;
    int bnd;
    if (e != 0) begin
      pos = (m_run != 0) ? (m_cnt + 1) % m_da : 0;
      bnd = (pos == 0);
      m_run = 1;
    end else begin
      pos = 0;
      bnd = 1;
      m_run = 0;
    end
    if (bnd != 0 && m_pend != 0) begin
      m_da = m_ds; m_ha = m_hs; m_pend = 0;
    end
    m_err = 0;
    if (l != 0) begin
      if (d >= 2 && h >= 1 && h < d) begin
        m_ds = d; m_hs = h; m_pend = 1;
      end else begin
        m_err = 1;
      end
    end
    m_cnt  = pos;
    m_clk  = (e != 0 && pos < m_ha);
    m_tick = (e != 0 && pos == 0);
  endtask

  initial begin
    int r_en, r_ld, r_dv, r_hi;
    int printed;

    tbl[0]  = mk(1, 0, 0, 0, 0, 1, 1, 0, 0);
    tbl[1]  = mk(1, 0, 0, 0, 1, 1, 0, 0, 0);
    tbl[2]  = mk(1, 0, 0, 0, 2, 0, 0, 0, 0);
    tbl[3]  = mk(1, 0, 0, 0, 3, 0, 0, 0, 0);
    tbl[4]  = mk(1, 0, 0, 0, 0, 1, 1, 0, 0);
    tbl[5]  = mk(1, 0, 0, 0, 1, 1, 0, 0, 0);
    tbl[6]  = mk(1, 1, 5, 2, 2, 0, 0, 1, 0);
    tbl[7]  = mk(1, 0, 0, 0, 3, 0, 0, 1, 0);
    tbl[8]  = mk(1, 0, 0, 0, 0, 1, 1, 0, 0);
    tbl[9]  = mk(1, 0, 0, 0, 1, 1, 0, 0, 0);
    tbl[10] = mk(1, 0, 0, 0, 2, 0, 0, 0, 0);
    tbl[11] = mk(1, 0, 0, 0, 3, 0, 0, 0, 0);
    tbl[12] = mk(1, 0, 0, 0, 4, 0, 0, 0, 0);
    tbl[13] = mk(1, 0, 0, 0, 0, 1, 1, 0, 0);
    tbl[14] = mk(1, 1, 1, 0, 1, 1, 0, 0, 1);
    tbl[15] = mk(1, 0, 0, 0, 2, 0, 0, 0, 0);
    tbl[16] = mk(1, 1, 6, 0, 3, 0, 0, 0, 1);
    tbl[17] = mk(1, 1, 6, 6, 4, 0, 0, 0, 1);
    tbl[18] = mk(1, 0, 0, 0, 0, 1, 1, 0, 0);

    // Reset defaults
    #1 rst_n = 1'b0;
    #1;
    chk("reset cnt", int'(cnt), 0);
    chk("reset clk_out", int'(clk_out), 0);
    chk("reset tick", int'(tick), 0);
    chk("reset pending", int'(pending), 0);
    chk("reset err", int'(err), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Default waveform, mid-period reprogram, invalid loads
    for (int i = 0; i < 19; i++) begin
      apply(tbl[i].en, tbl[i].ld, tbl[i].dv, tbl[i].hi);
      chk($sformatf("vec%0d cnt", i), int'(cnt), tbl[i].e_cnt);
      chk($sformatf("vec%0d clk_out", i), int'(clk_out), tbl[i].e_clk);
      chk($sformatf("vec%0d tick", i), int'(tick), tbl[i].e_tick);
      chk($sformatf("vec%0d pending", i), int'(pending), tbl[i].e_pend);
      chk($sformatf("vec%0d err", i), int'(err), tbl[i].e_err);
    end

    // Load on the terminal edge: shadow 3/1 applied, 8/3 stays pending
    apply(1, 1, 3, 1);
    chk("term cnt1", int'(cnt), 1);
    chk("term pend1", int'(pending), 1);
    apply(1, 0, 0, 0);
    apply(1, 0, 0, 0);
    apply(1, 0, 0, 0);
    chk("term cnt4", int'(cnt), 4);
    apply(1, 1, 8, 3);
    chk("term wrap cnt", int'(cnt), 0);
    chk("term wrap tick", int'(tick), 1);
    chk("term wrap clk_out", int'(clk_out), 1);
    chk("term wrap pending", int'(pending), 1);
    apply(1, 0, 0, 0);
    chk("3/1 cycle1 clk_out", int'(clk_out), 0);
    chk("3/1 cycle1 pending", int'(pending), 1);
    apply(1, 0, 0, 0);
    chk("3/1 cycle2 cnt", int'(cnt), 2);
    run_period(8, 3);
    chk("8/3 pending cleared", int'(pending), 0);
    run_period(8, 3);

    // Enable gating with a pending update
    apply(1, 1, 4, 1);
    chk("gate load pending", int'(pending), 1);
    apply(1, 0, 0, 0);
    apply(1, 0, 0, 0);
    chk("gate cnt2", int'(cnt), 2);
    apply(0, 0, 0, 0);
    chk("stop cnt", int'(cnt), 0);
    chk("stop clk_out", int'(clk_out), 0);
    chk("stop tick", int'(tick), 0);
    chk("stop pending applied", int'(pending), 0);
    apply(0, 0, 0, 0);
    chk("stopped tick", int'(tick), 0);
    run_period(4, 1);
    run_period(4, 1);

    // Maximum divisor, single-cycle high
    apply(1, 1, 65535, 1);
    chk("max load pending", int'(pending), 1);
    apply(1, 0, 0, 0);
    apply(1, 0, 0, 0);
    apply(1, 0, 0, 0);
    run_period(65535, 1);
    chk("max pending cleared", int'(pending), 0);
    apply(1, 1, 9, 4);
    chk("max wrap tick", int'(tick), 1);
    chk("max wrap clk_out", int'(clk_out), 1);
    chk("max wrap pending", int'(pending), 1);

    // Asynchronous reset between edges
    #2 rst_n = 1'b0;
    #1;
    chk("async cnt", int'(cnt), 0);
    chk("async clk_out", int'(clk_out), 0);
    chk("async tick", int'(tick), 0);
    chk("async pending", int'(pending), 0);
    chk("async err", int'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_period(4, 2);
    run_period(4, 2);

    // Randomized run against the reference model
    en = 1'b0;
    load = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    r_en = 1;
    printed = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) r_en = 1 - r_en;
      r_ld = ($urandom_range(0, 5) == 0);
      r_dv = $urandom_range(0, 12);
      r_hi = $urandom_range(0, 12);
      en   = (r_en != 0);
      load = (r_ld != 0);
      div  = 16'(r_dv);
      high = 16'(r_hi);
      @(posedge clk);
      model_step(r_en, r_ld, r_dv, r_hi);
      #1;
      n_cmp++;
      if (int'(cnt) != m_cnt || int'(clk_out) != m_clk || int'(tick) != m_tick ||
          int'(pending) != m_pend || int'(err) != m_err) begin
        n_bad++;
        if (printed < 10) begin
          printed++;
          $display("FAIL rand cycle %0d: got cnt=%0d clk=%0d tick=%0d pend=%0d err=%0d, expected cnt=%0d clk=%0d tick=%0d pend=%0d err=%0d",
                   c, cnt, clk_out, tick, pending, err, m_cnt, m_clk, m_tick, m_pend, m_err);
        end
      end
      load = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
